// File: rtl/par2ser_ctrl.sv
// par2ser_ctrl: burst sequencer between a parallel word source and a serial link.
// Per burst it pulses ask_for_data once per word, captures the word REQ_LAT
// cycles later and shifts it out MSB-first on sdata, qualified by sframe.
// Optional feature macro: PAR2SER_PARITY_EN appends one even-parity bit to
// every frame (frame length WIDTH+1 instead of WIDTH).
// All outputs are registered; reset is asynchronous and active-low.
module par2ser_ctrl #(
    parameter int WIDTH   = 4,  // parallel word width, 2..16
    parameter int BURST   = 3,  // words per start, 1..255
    parameter int REQ_LAT = 1,  // ask_for_data to data-valid latency, 1..7
    parameter int GAP_CYC = 2   // idle cycles between words, 0..15
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             ask_for_data,
    output logic             sdata,
    output logic             sframe,
    output logic             busy,
    output logic             done,
    output logic [7:0]       word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_SHIFT = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

`ifdef PAR2SER_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif

    // One shared 5-bit counter serves WAIT, SHIFT and GAP; each state
    // counts from 1 up to its own terminal value.
    localparam logic [4:0] FRAME_LAST = 5'(FRAME_LEN);
    localparam logic [4:0] WIDTH_C    = 5'(WIDTH);
    localparam logic [4:0] WAIT_LAST  = 5'(REQ_LAT - 1);
    localparam logic [4:0] GAP_LAST   = 5'(GAP_CYC);
    localparam logic [7:0] BURST_C    = 8'(BURST);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic             ask_q, ask_d;
    logic             sdata_q, sdata_d;
    logic             sframe_q, sframe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       word_cnt_q, word_cnt_d;
`ifdef PAR2SER_PARITY_EN
    logic             par_q, par_d;
`endif

    // Decoded events shared by the next-state and output logic.
    logic wait_last;
    logic capture;
    logic frame_end;
    logic burst_last;

    assign wait_last  = (state_q == S_WAIT) && (cnt_q == WAIT_LAST);
    assign capture    = ((state_q == S_REQ) && (REQ_LAT == 1)) || wait_last;
    assign frame_end  = (state_q == S_SHIFT) && (cnt_q == FRAME_LAST);
    assign burst_last = ((word_cnt_q + 8'd1) == BURST_C);

    // State register.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: REQ -> (WAIT) -> SHIFT -> GAP/REQ or DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = (REQ_LAT == 1) ? S_SHIFT : S_WAIT;
            end
            S_WAIT: begin
                if (wait_last) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (frame_end) begin
                    if (burst_last) begin
                        state_d = S_DONE;
                    end else if (GAP_CYC == 0) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_REQ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath logic: next values of every registered output,
    // the shared counter and the shift register.
    always_comb begin
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        sdata_d    = 1'b0;
        sframe_d   = 1'b0;
        word_cnt_d = word_cnt_q;
`ifdef PAR2SER_PARITY_EN
        par_d      = par_q;
`endif
        // Control outputs follow the state being entered so they are
        // aligned with that state while still coming straight from flops.
        ask_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_cnt_d = 8'd0;
                end
            end
            S_REQ: begin
                cnt_d = 5'd1;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 5'd1;
            end
            S_SHIFT: begin
                if (frame_end) begin
                    // Frame complete: line goes quiet, counter restarts for GAP.
                    word_cnt_d = word_cnt_q + 8'd1;
                    cnt_d      = 5'd1;
                    sh_d       = '0;
                end else begin
                    sframe_d = 1'b1;
                    cnt_d    = cnt_q + 5'd1;
`ifdef PAR2SER_PARITY_EN
                    if (cnt_q < WIDTH_C) begin
                        sdata_d = sh_q[WIDTH-1];
                        sh_d    = {sh_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sdata_d = par_q;
                    end
`else
                    if (cnt_q < WIDTH_C) begin
                        sdata_d = sh_q[WIDTH-1];
                    end
                    sh_d = {sh_q[WIDTH-2:0], 1'b0};
`endif
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 5'd1;
            end
            S_DONE: begin
                cnt_d = 5'd0;
            end
            default: begin
                cnt_d = 5'd0;
            end
        endcase

        // Capture edge: the MSB goes straight onto the line, the remaining
        // bits are parked in the shift register.
        if (capture) begin
            sdata_d  = data[WIDTH-1];
            sframe_d = 1'b1;
            sh_d     = {data[WIDTH-2:0], 1'b0};
            cnt_d    = 5'd1;
`ifdef PAR2SER_PARITY_EN
            par_d    = ^data;
`endif
        end
    end

    // Datapath and output registers.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            sh_q       <= '0;
            ask_q      <= 1'b0;
            sdata_q    <= 1'b0;
            sframe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            word_cnt_q <= 8'd0;
`ifdef PAR2SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            ask_q      <= ask_d;
            sdata_q    <= sdata_d;
            sframe_q   <= sframe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            word_cnt_q <= word_cnt_d;
`ifdef PAR2SER_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign ask_for_data = ask_q;
    assign sdata        = sdata_q;
    assign sframe       = sframe_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_par2ser_ctrl.sv
// Directed bench for par2ser_ctrl: a default-parameter instance plus a
// REQ_LAT=3 / GAP_CYC=0 instance, each fed by a source that increments its
// word 28 ns after every ask_for_data rise.
module tb_par2ser_ctrl;

`ifdef PAR2SER_PARITY_EN
    localparam int FLEN = 5;
`else
    localparam int FLEN = 4;
`endif
    localparam int PER = 1 + 0 + FLEN + 2;   // cycles per word, defaults

    logic       sclk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [3:0] data = 4'd0;
    logic       ask, sdata, sframe, busy, done;
    logic [7:0] word_cnt;

    logic       start_b = 1'b0;
    logic [3:0] data_b = 4'd0;
    logic       ask_b, sdata_b, sframe_b, busy_b, done_b;
    logic [7:0] word_cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    par2ser_ctrl dut (
        .sclk(sclk), .rst(rst), .start(start), .data(data),
        .ask_for_data(ask), .sdata(sdata), .sframe(sframe),
        .busy(busy), .done(done), .word_cnt(word_cnt)
    );

    par2ser_ctrl #(.WIDTH(4), .BURST(3), .REQ_LAT(3), .GAP_CYC(0)) dut_b (
        .sclk(sclk), .rst(rst), .start(start_b), .data(data_b),
        .ask_for_data(ask_b), .sdata(sdata_b), .sframe(sframe_b),
        .busy(busy_b), .done(done_b), .word_cnt(word_cnt_b)
    );

    always #50 sclk = ~sclk;

    // Word sources.
    bit src_auto = 1'b1;
    always @(posedge ask) begin
        if (src_auto) begin
            #28 data = data + 4'd1;
        end
    end
    always @(posedge ask_b) begin
        #28 data_b = data_b + 4'd1;
    end

    // Monitor for the default instance: logs asks, frames and done pulses.
    int         cyc = 0;
    int         ask_n = 0;
    int         ask_cyc[$];
    logic [7:0] fr_val[$];
    int         fr_len[$];
    int         fr_rise[$];
    int         fr_fall[$];
    int         done_n = 0;
    int         done_cyc = 0;
    logic [7:0] done_wc = 8'd0;
    logic       busy_after_done = 1'b1;
    int         sd_bad = 0;
    logic [7:0] cur = 8'd0;
    int         cur_len = 0;
    int         cur_rise = 0;
    logic       prev_sf = 1'b0;
    logic       prev_done = 1'b0;

    always @(negedge sclk) begin
        cyc = cyc + 1;
        if (ask) begin
            ask_n = ask_n + 1;
            ask_cyc.push_back(cyc);
        end
        if (sframe) begin
            if (!prev_sf) begin
                cur = 8'd0;
                cur_len = 0;
                cur_rise = cyc;
            end
            cur = {cur[6:0], sdata};
            cur_len = cur_len + 1;
        end else if (prev_sf) begin
            fr_val.push_back(cur);
            fr_len.push_back(cur_len);
            fr_rise.push_back(cur_rise);
            fr_fall.push_back(cyc);
            $display("frame %0d: bits=%b len=%0d rise=%0d fall=%0d",
                     fr_val.size() - 1, cur, cur_len, cur_rise, cyc);
        end
        if (!sframe && sdata) sd_bad = sd_bad + 1;
        if (prev_done) busy_after_done = busy;
        if (done) begin
            done_n = done_n + 1;
            done_cyc = cyc;
            done_wc = word_cnt;
        end
        prev_done = done;
        prev_sf = sframe;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sclk);
            #1;
        end
    endtask

    // Waits up to 60 cycles for done_n to exceed db; a timeout is a failure.
    task automatic wait_done(input int db, input string tag);
        int k;
        k = 0;
        while (done_n <= db && k < 60) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (done_n <= db) begin
            n_bad++;
            $display("FAIL %s_timeout: done not seen within 60 cycles, required one pulse", tag);
        end
    endtask

    task automatic test_reset;
        logic [12:0] obs;
        rst = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            obs = {ask, sdata, sframe, busy, done, word_cnt};
            n_cmp++;
            if (obs !== 13'd0) begin
                n_bad++;
                $display("FAIL reset_outputs: cycle %0d got %b required 0", i, obs);
            end
        end
        rst = 1'b1;
        tick(1);
        start = 1'b0;
        n_cmp++;
        if (ask !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ask: got %b required 1", ask);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_busy: got %b required 1", busy);
        end
        wait_done(0, "reset_burst");
        tick(2);
    endtask

    task automatic test_burst;
        int fb, ab, db, ac;
        logic [7:0] exp_v[3];
`ifdef PAR2SER_PARITY_EN
        exp_v = '{8'h03, 8'h05, 8'h06};
`else
        exp_v = '{8'h01, 8'h02, 8'h03};
`endif
        data = 4'd0;
        fb = fr_val.size();
        ab = ask_n;
        db = done_n;
        ac = ask_cyc.size();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(db, "burst");
        tick(3);
        n_cmp++;
        if (ask_n - ab !== 3) begin
            n_bad++;
            $display("FAIL burst_asks: got %0d required 3", ask_n - ab);
        end
        n_cmp++;
        if (fr_val.size() - fb !== 3) begin
            n_bad++;
            $display("FAIL burst_frames: got %0d required 3", fr_val.size() - fb);
        end
        if (fr_val.size() >= fb + 3 && ask_cyc.size() >= ac + 1) begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (fr_val[fb+i] !== exp_v[i] || fr_len[fb+i] !== FLEN) begin
                    n_bad++;
                    $display("FAIL burst_word%0d: got %b len %0d required %b len %0d",
                             i, fr_val[fb+i], fr_len[fb+i], exp_v[i], FLEN);
                end
            end
            n_cmp++;
            if (fr_rise[fb] - ask_cyc[ac] !== 1) begin
                n_bad++;
                $display("FAIL burst_latency: got %0d required 1", fr_rise[fb] - ask_cyc[ac]);
            end
            n_cmp++;
            if (fr_rise[fb+1] - fr_rise[fb] !== PER) begin
                n_bad++;
                $display("FAIL burst_period: got %0d required %0d", fr_rise[fb+1] - fr_rise[fb], PER);
            end
            n_cmp++;
            if (done_cyc !== fr_fall[fb+2]) begin
                n_bad++;
                $display("FAIL burst_done_timing: got %0d required %0d", done_cyc, fr_fall[fb+2]);
            end
        end
        n_cmp++;
        if (done_n - db !== 1) begin
            n_bad++;
            $display("FAIL burst_done_count: got %0d required 1", done_n - db);
        end
        n_cmp++;
        if (done_wc !== 8'd3) begin
            n_bad++;
            $display("FAIL burst_word_cnt: got %0d required 3", done_wc);
        end
        n_cmp++;
        if (busy_after_done !== 1'b0) begin
            n_bad++;
            $display("FAIL burst_busy_after_done: got %b required 0", busy_after_done);
        end
        n_cmp++;
        if (word_cnt !== 8'd3) begin
            n_bad++;
            $display("FAIL burst_word_cnt_hold: got %0d required 3", word_cnt);
        end
        n_cmp++;
        if (sd_bad !== 0) begin
            n_bad++;
            $display("FAIL burst_sdata_idle: got %0d bits outside frame required 0", sd_bad);
        end
    endtask

    task automatic test_ignore_start;
        int fb, ab, db, a_done;
        data = 4'd0;
        fb = fr_val.size();
        ab = ask_n;
        db = done_n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(10);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(db, "ignore");
        a_done = ask_n;
        tick(10);
        n_cmp++;
        if (ask_n - ab !== 3) begin
            n_bad++;
            $display("FAIL ignore_asks: got %0d required 3", ask_n - ab);
        end
        n_cmp++;
        if (ask_n !== a_done) begin
            n_bad++;
            $display("FAIL ignore_no_requeue: got %0d asks after done required 0", ask_n - a_done);
        end
        n_cmp++;
        if (fr_val.size() - fb !== 3) begin
            n_bad++;
            $display("FAIL ignore_frames: got %0d required 3", fr_val.size() - fb);
        end
    endtask

    task automatic test_back_to_back;
        int db, ac, d1;
        data = 4'd0;
        db = done_n;
        ac = ask_cyc.size();
        start = 1'b1;
        wait_done(db, "b2b_first");
        d1 = done_cyc;
        tick(2);
        start = 1'b0;
        n_cmp++;
        if (ask_cyc.size() < ac + 4 || ask_cyc[ask_cyc.size() > ac + 3 ? ac + 3 : 0] !== d1 + 2) begin
            n_bad++;
            $display("FAIL b2b_retrigger: asks %0d, 4th ask cycle vs done %0d required done+2",
                     ask_cyc.size() - ac, d1);
        end
        wait_done(db + 1, "b2b_second");
        tick(2);
    endtask

    task automatic test_reset_mid;
        int ab, sf_seen;
        data = 4'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(PER + 1);
        n_cmp++;
        if (sframe !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pre_sframe: got %b required 1", sframe);
        end
        #10 rst = 1'b0;
        #1;
        n_cmp++;
        if ({sframe, busy, sdata} !== 3'b000) begin
            n_bad++;
            $display("FAIL midrst_async: sframe/busy/sdata got %b required 000", {sframe, busy, sdata});
        end
        tick(2);
        rst = 1'b1;
        ab = ask_n;
        sf_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (sframe) sf_seen++;
        end
        n_cmp++;
        if (ask_n !== ab) begin
            n_bad++;
            $display("FAIL midrst_no_ask: got %0d asks required 0", ask_n - ab);
        end
        n_cmp++;
        if (sf_seen !== 0 || busy !== 1'b0 || word_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL midrst_idle: sframe cycles %0d busy %b word_cnt %0d required 0 0 0",
                     sf_seen, busy, word_cnt);
        end
    endtask

    task automatic test_lat3;
        int r1, f1, a2, k, wc_seen;
        logic [7:0] bits;
        logic [7:0] exp_bits;
        logic       seen_done;
`ifdef PAR2SER_PARITY_EN
        exp_bits = 8'h03;
`else
        exp_bits = 8'h01;
`endif
        data_b = 4'd0;
        r1 = -1; f1 = -1; a2 = -1; wc_seen = -1;
        bits = 8'd0;
        seen_done = 1'b0;
        start_b = 1'b1;
        tick(1);
        start_b = 1'b0;
        n_cmp++;
        if (ask_b !== 1'b1) begin
            n_bad++;
            $display("FAIL lat3_first_ask: got %b required 1", ask_b);
        end
        k = 0;
        while (!seen_done && k < 60) begin
            tick(1);
            k++;
            if (sframe_b && r1 < 0) r1 = k;
            if (r1 >= 0 && f1 < 0) begin
                if (sframe_b) bits = {bits[6:0], sdata_b};
                else f1 = k;
            end
            if (ask_b && a2 < 0) a2 = k;
            if (done_b) begin
                seen_done = 1'b1;
                wc_seen = int'(word_cnt_b);
            end
        end
        n_cmp++;
        if (r1 !== 3) begin
            n_bad++;
            $display("FAIL lat3_sframe_rise: got %0d cycles after ask required 3", r1);
        end
        n_cmp++;
        if (bits !== exp_bits || f1 - r1 !== FLEN) begin
            n_bad++;
            $display("FAIL lat3_frame: got %b len %0d required %b len %0d", bits, f1 - r1, exp_bits, FLEN);
        end
        n_cmp++;
        if (a2 !== f1) begin
            n_bad++;
            $display("FAIL lat3_gap0_ask: ask at %0d sframe fall at %0d required equal", a2, f1);
        end
        n_cmp++;
        if (!seen_done || wc_seen !== 3) begin
            n_bad++;
            $display("FAIL lat3_done: done %b word_cnt %0d required 1 3", seen_done, wc_seen);
        end
        tick(2);
    endtask

    task automatic test_words;
        int fb, db;
        logic [7:0] exp0, exp1;
`ifdef PAR2SER_PARITY_EN
        exp0 = 8'h0F;   // 0,1,1,1,1
        exp1 = 8'h06;   // 0,0,1,1,0
`else
        exp0 = 8'h07;
        exp1 = 8'h03;
`endif
        src_auto = 1'b0;
        data = 4'b0111;
        fb = fr_val.size();
        db = done_n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        data = 4'b0011;
        wait_done(db, "words");
        tick(2);
        src_auto = 1'b1;
        n_cmp++;
        if (fr_val.size() < fb + 2 || fr_val[fb] !== exp0 || fr_len[fb] !== FLEN) begin
            n_bad++;
            $display("FAIL words_0111: got %b required %b len %0d",
                     fr_val.size() > fb ? fr_val[fb] : 8'hxx, exp0, FLEN);
        end
        n_cmp++;
        if (fr_val.size() < fb + 2 || fr_val[fb+1] !== exp1 || fr_len[fb+1] !== FLEN) begin
            n_bad++;
            $display("FAIL words_0011: got %b required %b len %0d",
                     fr_val.size() > fb + 1 ? fr_val[fb+1] : 8'hxx, exp1, FLEN);
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_lat3();
        test_words();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
